// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer that owns the select lines of a shared 4:1 mux.
// It grants a requester only after the mux select has settled, and it limits how long that grant lasts.
module mux_rr_sequencer #(
    parameter int SETTLE_CYC = 2,
    parameter int HOLD_MAX   = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [3:0]       done,
    output logic [3:0]       gnt,
    output logic             gnt_valid,
    output logic             address0,
    output logic             address1,
    output logic             timeout,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWN    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_nxt;
    logic [1:0]       addr, addr_nxt;
    logic [1:0]       last_owner, last_owner_nxt;
    logic [1:0]       winner;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic [3:0]       gnt_nxt;
    logic             timeout_nxt;
    logic             any_req;
    logic             release_own;
    logic             hold_expired;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign any_req      = |req;
    assign release_own  = done[addr] | ~req[addr];
    assign hold_expired = (hold_cnt == HOLD_LAST);

    // Scan starts just after the previous owner, so that owner has the lowest priority.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        idx    = '0;
        found  = 1'b0;
        winner = last_owner + 2'd1;
        for (int i = 1; i < 5; i++) begin
            idx = last_owner + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        last_owner_nxt = last_owner;
        settle_cnt_nxt = settle_cnt;
        hold_cnt_nxt   = hold_cnt;
        gnt_nxt        = gnt;
        timeout_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                gnt_nxt      = 4'b0000;
                hold_cnt_nxt = '0;
                if (any_req) begin
                    addr_nxt       = winner;
                    settle_cnt_nxt = '0;
                    if (SETTLE_CYC == 0) begin
                        state_nxt      = OWN;
                        gnt_nxt        = onehot(winner);
                        last_owner_nxt = winner;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                gnt_nxt = 4'b0000;
                if (!req[addr]) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt      = OWN;
                    gnt_nxt        = onehot(addr);
                    hold_cnt_nxt   = '0;
                    last_owner_nxt = addr;
                end else begin
                    settle_cnt_nxt = settle_cnt + 1'b1;
                end
            end
            OWN: begin
                if (release_own || hold_expired) begin
                    // A release in the same cycle as expiry wins; no timeout pulse then.
                    gnt_nxt      = 4'b0000;
                    hold_cnt_nxt = '0;
                    timeout_nxt  = ~release_own;
                    if (any_req) begin
                        addr_nxt       = winner;
                        settle_cnt_nxt = '0;
                        if (SETTLE_CYC == 0) begin
                            state_nxt      = OWN;
                            gnt_nxt        = onehot(winner);
                            last_owner_nxt = winner;
                        end else begin
                            state_nxt = SETTLE;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr       <= 2'b00;
            last_owner <= 2'd3;
            settle_cnt <= '0;
            hold_cnt   <= '0;
            gnt        <= 4'b0000;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            last_owner <= last_owner_nxt;
            settle_cnt <= settle_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            gnt        <= gnt_nxt;
            gnt_valid  <= |gnt_nxt;
            timeout    <= timeout_nxt;
        end
    end

    assign address0  = addr[0];
    assign address1  = addr[1];
    assign fsm_state = state;

endmodule
